// File: rtl/graphite_vram_arbiter.sv
// graphite_vram_arbiter: merges NUM_CH VRAM master channels onto one vram_* bus.
// Arbitration is round-robin. A channel can optionally lock the bus for a burst
// of up to BURST_MAX back-to-back grants.
// Ports:
//   clk, reset_ni                   clock, synchronous active-low reset
//   ch_sel_i/wr_i/lock_i            per-channel request, direction, burst-lock request
//   ch_mask_i/addr_i/data_i         packed per-channel fields, channel n at [n*W +: W]
//   ch_ack_o, ch_data_o             one-hot completion pulse and shared read data
//   grant_o                         one-hot owner of the access in flight
//   vram_sel_o/wr_o/mask_o/addr_o/data_out_o   downstream request (registered)
//   vram_ack_i, vram_data_in_i      downstream completion and read data
module graphite_vram_arbiter #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MASK_W    = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic [NUM_CH-1:0]          ch_sel_i,
  input  logic [NUM_CH-1:0]          ch_wr_i,
  input  logic [NUM_CH-1:0]          ch_lock_i,
  input  logic [NUM_CH*MASK_W-1:0]   ch_mask_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]          ch_ack_o,
  output logic [DATA_W-1:0]          ch_data_o,
  output logic [NUM_CH-1:0]          grant_o,
  output logic                       vram_sel_o,
  output logic                       vram_wr_o,
  output logic [MASK_W-1:0]          vram_mask_o,
  output logic [ADDR_W-1:0]          vram_addr_o,
  output logic [DATA_W-1:0]          vram_data_out_o,
  input  logic                       vram_ack_i,
  input  logic [DATA_W-1:0]          vram_data_in_i
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   last_grant, last_grant_d;
  logic [IDX_W-1:0]   grant_idx, grant_idx_d;
  logic [IDX_W-1:0]   lock_ch, lock_ch_d;
  logic               lock_act, lock_act_d;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_d;

  logic [NUM_CH-1:0]  grant_d, ch_ack_d;
  logic [DATA_W-1:0]  ch_data_d;
  logic               vram_sel_d, vram_wr_d;
  logic [MASK_W-1:0]  vram_mask_d;
  logic [ADDR_W-1:0]  vram_addr_d;
  logic [DATA_W-1:0]  vram_data_out_d;

  logic [IDX_W-1:0]   rr_idx, win_idx;
  logic               lock_hit;

  logic [MASK_W-1:0]  mask_a [NUM_CH];
  logic [ADDR_W-1:0]  addr_a [NUM_CH];
  logic [DATA_W-1:0]  data_a [NUM_CH];

  // Unpack the flat per-channel buses so the winner can be indexed directly
  for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
    assign mask_a[n] = ch_mask_i[n*MASK_W +: MASK_W];
    assign addr_a[n] = ch_addr_i[n*ADDR_W +: ADDR_W];
    assign data_a[n] = ch_data_i[n*DATA_W +: DATA_W];
  end

  // Channel index base+off modulo NUM_CH; off never exceeds NUM_CH
  function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return IDX_W'(s);
  endfunction

  // Round-robin pick: scan downward so the smallest offset from last_grant wins
  always_comb begin
    rr_idx = last_grant;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      if (ch_sel_i[rr_cand(last_grant, i)]) rr_idx = rr_cand(last_grant, i);
    end
  end

  assign lock_hit = lock_act && ch_sel_i[lock_ch];
  assign win_idx  = lock_hit ? lock_ch : rr_idx;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state           <= IDLE;
      last_grant      <= IDX_W'(NUM_CH - 1);
      grant_idx       <= '0;
      lock_ch         <= '0;
      lock_act        <= 1'b0;
      burst_cnt       <= '0;
      grant_o         <= '0;
      ch_ack_o        <= '0;
      ch_data_o       <= '0;
      vram_sel_o      <= 1'b0;
      vram_wr_o       <= 1'b0;
      vram_mask_o     <= '0;
      vram_addr_o     <= '0;
      vram_data_out_o <= '0;
    end else begin
      state           <= state_d;
      last_grant      <= last_grant_d;
      grant_idx       <= grant_idx_d;
      lock_ch         <= lock_ch_d;
      lock_act        <= lock_act_d;
      burst_cnt       <= burst_cnt_d;
      grant_o         <= grant_d;
      ch_ack_o        <= ch_ack_d;
      ch_data_o       <= ch_data_d;
      vram_sel_o      <= vram_sel_d;
      vram_wr_o       <= vram_wr_d;
      vram_mask_o     <= vram_mask_d;
      vram_addr_o     <= vram_addr_d;
      vram_data_out_o <= vram_data_out_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    last_grant_d    = last_grant;
    grant_idx_d     = grant_idx;
    lock_ch_d       = lock_ch;
    lock_act_d      = lock_act;
    burst_cnt_d     = burst_cnt;
    grant_d         = grant_o;
    ch_ack_d        = '0;
    ch_data_d       = ch_data_o;
    vram_sel_d      = vram_sel_o;
    vram_wr_d       = vram_wr_o;
    vram_mask_d     = vram_mask_o;
    vram_addr_d     = vram_addr_o;
    vram_data_out_d = vram_data_out_o;

    case (state)
      IDLE: begin
        // A locked channel that stopped requesting gives up its burst
        if (lock_act && !ch_sel_i[lock_ch]) begin
          lock_act_d  = 1'b0;
          burst_cnt_d = '0;
        end
        if (|ch_sel_i) begin
          grant_idx_d     = win_idx;
          last_grant_d    = win_idx;
          grant_d         = NUM_CH'(1) << win_idx;
          vram_sel_d      = 1'b1;
          vram_wr_d       = ch_wr_i[win_idx];
          vram_mask_d     = mask_a[win_idx];
          vram_addr_d     = addr_a[win_idx];
          vram_data_out_d = data_a[win_idx];
          state_d         = ISSUE;
        end
      end

      ISSUE: begin
        if (vram_ack_i) begin
          vram_sel_d = 1'b0;
          ch_data_d  = vram_data_in_i;
          ch_ack_d   = grant_o;
          state_d    = RESP;
        end
      end

      RESP: begin
        grant_d = '0;
        // Extend the burst only while the owner asks and the cap is not reached
        if (ch_lock_i[grant_idx] && (burst_cnt < CNT_W'(BURST_MAX - 1))) begin
          lock_act_d  = 1'b1;
          lock_ch_d   = grant_idx;
          burst_cnt_d = burst_cnt + CNT_W'(1);
        end else begin
          lock_act_d  = 1'b0;
          burst_cnt_d = '0;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_graphite_vram_arbiter.sv
// Directed self-checking bench for graphite_vram_arbiter (3 channels, BURST_MAX=4).
module tb_graphite_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [2:0]  ch_sel_i, ch_wr_i, ch_lock_i;
  logic [11:0] ch_mask_i;
  logic [95:0] ch_addr_i;
  logic [47:0] ch_data_i;
  logic [2:0]  ch_ack_o;
  logic [15:0] ch_data_o;
  logic [2:0]  grant_o;
  logic        vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [31:0] vram_addr_o;
  logic [15:0] vram_data_out_o;
  logic        vram_ack_i;
  logic [15:0] vram_data_in_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  graphite_vram_arbiter #(
    .NUM_CH(3), .ADDR_W(32), .DATA_W(16), .MASK_W(4), .BURST_MAX(4)
  ) dut (
    .clk(clk), .reset_ni(reset_ni),
    .ch_sel_i(ch_sel_i), .ch_wr_i(ch_wr_i), .ch_lock_i(ch_lock_i),
    .ch_mask_i(ch_mask_i), .ch_addr_i(ch_addr_i), .ch_data_i(ch_data_i),
    .ch_ack_o(ch_ack_o), .ch_data_o(ch_data_o), .grant_o(grant_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o),
    .vram_ack_i(vram_ack_i), .vram_data_in_i(vram_data_in_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int n, input logic sel, input logic wr, input logic lock,
                        input logic [3:0] mask, input logic [31:0] addr, input logic [15:0] data);
    ch_sel_i[n]              = sel;
    ch_wr_i[n]               = wr;
    ch_lock_i[n]             = lock;
    ch_mask_i[n*4 +: 4]      = mask;
    ch_addr_i[n*32 +: 32]    = addr;
    ch_data_i[n*16 +: 16]    = data;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vsel"}, vram_sel_o, 0);
    chk({tag, "_vwr"}, vram_wr_o, 0);
    chk({tag, "_vmask"}, vram_mask_o, 0);
    chk({tag, "_vaddr"}, vram_addr_o, 0);
    chk({tag, "_vdata"}, vram_data_out_o, 0);
    chk({tag, "_ack"}, ch_ack_o, 0);
    chk({tag, "_cdata"}, ch_data_o, 0);
    chk({tag, "_grant"}, grant_o, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset_ni = 1'b0;
    repeat (cycles) step();
    reset_ni = 1'b1;
  endtask

  // Wait for the downstream request, ack it after lat cycles, check the upstream pulse
  task automatic serve(input int lat, input logic [15:0] rd, output logic [2:0] g);
    int n = 0;
    while (!vram_sel_o && n < 20) begin
      step();
      n++;
    end
    chk("sel_wait", (n < 20), 1);
    g = grant_o;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("ack_early", ch_ack_o, 0);
      chk("sel_hold", vram_sel_o, 1);
    end
    vram_ack_i     = 1'b1;
    vram_data_in_i = rd;
    step();
    vram_ack_i     = 1'b0;
    vram_data_in_i = '0;
    chk("ack_pulse", ch_ack_o, g);
    chk("ack_data", ch_data_o, rd);
    chk("sel_drop", vram_sel_o, 0);
    step();
    chk("ack_clear", ch_ack_o, 0);
  endtask

  logic [2:0] g;
  logic [2:0] exp_b [10];

  initial begin
    reset_ni = 1'b0; vram_ack_i = 1'b0; vram_data_in_i = '0;
    ch_sel_i = '0; ch_wr_i = '0; ch_lock_i = '0;
    ch_mask_i = '0; ch_addr_i = '0; ch_data_i = '0;

    // Reset values, during reset and one cycle after release
    do_reset(4);
    chk_zero("rst_hold");
    step();
    chk_zero("rst_rel");
    chk("rst_last_grant", dut.last_grant, 2);
    chk("rst_burst_cnt", dut.burst_cnt, 0);
    chk("rst_lock", dut.lock_act, 0);

    // Single write from ch1, ack two cycles after vram_sel_o
    set_ch(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h1000, 16'hBEEF);
    serve(2, 16'h0000, g);
    chk("wr_grant", g, 3'b010);
    chk("wr_vwr", vram_wr_o, 1);
    chk("wr_mask", vram_mask_o, 4'hF);
    chk("wr_addr", vram_addr_o, 32'h1000);
    chk("wr_data", vram_data_out_o, 16'hBEEF);
    set_ch(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 16'h0);

    // Read from ch2 with data returned on ack
    set_ch(2, 1'b1, 1'b0, 1'b0, 4'h0, 32'h20, 16'h0);
    serve(0, 16'h1234, g);
    chk("rd_grant", g, 3'b100);
    chk("rd_vwr", vram_wr_o, 0);
    chk("rd_addr", vram_addr_o, 32'h20);
    chk("rd_cdata", ch_data_o, 16'h1234);
    set_ch(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 16'h0);

    // ch0 drops sel during ISSUE; access still completes
    set_ch(0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 16'h5A5A);
    step();
    chk("drop_grant", grant_o, 3'b001);
    ch_sel_i = '0;
    step();
    chk("drop_sel_hold", vram_sel_o, 1);
    vram_ack_i = 1'b1;
    step();
    vram_ack_i = 1'b0;
    chk("drop_ack", ch_ack_o, 3'b001);
    step();
    chk("drop_ack_clear", ch_ack_o, 0);
    step();
    chk("drop_no_regrant", vram_sel_o, 0);

    // Round-robin with all channels requesting continuously
    do_reset(2);
    for (int n = 0; n < 3; n++) set_ch(n, 1'b1, 1'b0, 1'b0, 4'h0, 32'(n), 16'h0);
    for (int k = 0; k < 9; k++) begin
      serve(0, 16'(k), g);
      chk($sformatf("rr_%0d", k), g, 3'b001 << (k % 3));
    end
    ch_sel_i = '0;

    // Burst lock on ch0 with ch1 competing, cap of 4 grants
    do_reset(2);
    exp_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    set_ch(0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h100, 16'h0);
    set_ch(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200, 16'h0);
    for (int k = 0; k < 10; k++) begin
      serve(0, 16'h0, g);
      chk($sformatf("burst_%0d", k), g, exp_b[k]);
    end
    ch_sel_i = '0; ch_lock_i = '0;

    // ch2 locks then stops requesting; ch0 takes the next grant
    set_ch(2, 1'b1, 1'b0, 1'b1, 4'h0, 32'h300, 16'h0);
    serve(0, 16'h0, g);
    chk("rel_first", g, 3'b100);
    chk("rel_locked", dut.lock_act, 1);
    chk("rel_cnt1", dut.burst_cnt, 1);
    set_ch(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 16'h0);
    set_ch(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h400, 16'h0);
    step();
    chk("rel_grant", grant_o, 3'b001);
    chk("rel_cnt0", dut.burst_cnt, 0);
    chk("rel_unlocked", dut.lock_act, 0);
    serve(0, 16'h0, g);
    ch_sel_i = '0;

    // Reset during ISSUE, then a stray ack
    set_ch(1, 1'b1, 1'b1, 1'b0, 4'h1, 32'h500, 16'h7777);
    step();
    chk("mid_sel", vram_sel_o, 1);
    step();
    reset_ni = 1'b0;
    step();
    chk("mid_rst_sel", vram_sel_o, 0);
    chk("mid_rst_grant", grant_o, 0);
    reset_ni = 1'b1;
    ch_sel_i = '0;
    vram_ack_i = 1'b1;
    step();
    vram_ack_i = 1'b0;
    chk("mid_stray_ack", ch_ack_o, 0);
    chk("mid_stray_sel", vram_sel_o, 0);
    step();
    chk("mid_stray_ack2", ch_ack_o, 0);
    set_ch(1, 1'b1, 1'b1, 1'b0, 4'h1, 32'h600, 16'h8888);
    serve(1, 16'h0, g);
    chk("mid_regrant", g, 3'b010);
    chk("mid_addr", vram_addr_o, 32'h600);
    ch_sel_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
